// File: rtl/avr_prog_loader_if.sv
// -----------------------------------------------------------------------------
// avr_prog_loader_if
// Byte-stream handshake between the host/UART side and the program loader.
//   in_valid  : in_data holds a byte (driven by the byte source)
//   in_data   : stream byte (driven by the byte source)
//   in_ready  : loader accepts a byte this cycle (driven by the loader)
// A byte transfers on any clock edge where in_valid && in_ready.
// Modports: master = byte source, slave = loader.
// -----------------------------------------------------------------------------
interface avr_prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/avr_prog_loader.sv
// -----------------------------------------------------------------------------
// avr_prog_loader
// Receives a framed byte stream (SYNC, LEN_L, LEN_H, 2*LEN data bytes, CSUM)
// and writes 16-bit instruction words into the program memory write port.
// The CPU/fetch stage is held in reset via cpu_hold until a load completes
// with a good checksum.
//
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   stream       : byte-stream slave (in_valid, in_data, in_ready)
//   wr_en        : program memory write strobe, one cycle per word
//   wr_addr      : program memory word address
//   wr_data      : word to write (first byte of the pair in [15:8])
//   cpu_hold     : OR'd into the CPU/fetch reset by the top level
//   done         : last load completed with a good checksum
//   error        : last load aborted or failed
//   words_loaded : words written in the current/last frame
//
// Optional feature macro: LOADER_TIMEOUT_EN
//   When defined, a stalled frame (no accepted byte for TIMEOUT_CYCLES cycles
//   while inside a frame) aborts to the error state. When undefined, a stalled
//   frame waits indefinitely.
// -----------------------------------------------------------------------------
module avr_prog_loader #(
    parameter int         ADDR_W         = 9,
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                CLK,
    input  logic                RST,
    avr_prog_loader_if.slave    stream,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [15:0]         wr_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_L, LEN_H, DATA_HI, DATA_LO, CSUM, DONE, ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  len_l;
    logic [15:0] len;
    logic [7:0]  hi;
    logic [7:0]  sum;
    logic        accept;
    logic [15:0] len_word;
    logic        len_too_big;
    logic        last_word;
    logic        sync_seen;

    // The loader never back-pressures; it only refuses bytes while in reset.
    assign stream.in_ready = !RST;
    assign accept          = stream.in_valid && stream.in_ready;
    assign sync_seen       = (stream.in_data == SYNC_BYTE);

    // LEN_H arrives on the bus while LEN_L is already stored.
    assign len_word    = {stream.in_data, len_l};
    assign len_too_big = ({1'b0, len_word} > (17'd1 << ADDR_W));
    // words_loaded still holds the index of the word being completed.
    assign last_word   = ((17'(words_loaded) + 17'd1) == {1'b0, len});

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] timer;
    logic        in_frame;
    logic        timeout_hit;

    assign in_frame    = (state == LEN_L) || (state == LEN_H) || (state == DATA_HI) ||
                         (state == DATA_LO) || (state == CSUM);
    assign timeout_hit = in_frame && !accept && (timer == 32'(TIMEOUT_CYCLES));

    // Counts idle cycles inside a frame; any accepted byte or leaving the
    // frame states starts it over.
    always_ff @(posedge CLK) begin
        if (RST || accept || !in_frame) begin
            timer <= '0;
        end else if (timer != 32'(TIMEOUT_CYCLES)) begin
            timer <= timer + 32'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every transition is driven by an accepted byte,
    // except the optional inter-byte timeout.
    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                IDLE, DONE, ERR: if (sync_seen) next_state = LEN_L;
                LEN_L:           next_state = LEN_H;
                LEN_H: begin
                    if (len_too_big)          next_state = ERR;
                    else if (len_word == '0)  next_state = CSUM;
                    else                      next_state = DATA_HI;
                end
                DATA_HI:         next_state = DATA_LO;
                DATA_LO:         next_state = last_word ? CSUM : DATA_HI;
                CSUM:            next_state = ((sum + stream.in_data) == 8'h00) ? DONE : ERR;
                default:         next_state = IDLE;
            endcase
        end
`ifdef LOADER_TIMEOUT_EN
        if (timeout_hit) begin
            next_state = ERR;
        end
`endif
    end

    // Datapath and status flags. Status changes are keyed off state entry so
    // a timeout abort and a bad checksum take the same path into ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            len_l        <= '0;
            len          <= '0;
            hi           <= '0;
            sum          <= '0;
        end else begin
            wr_en <= 1'b0;
            // wr_addr stays put during the strobe and advances right after it.
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (accept) begin
                case (state)
                    LEN_L: begin
                        len_l <= stream.in_data;
                        sum   <= sum + stream.in_data;
                    end
                    LEN_H: begin
                        len <= len_word;
                        sum <= sum + stream.in_data;
                    end
                    DATA_HI: begin
                        hi  <= stream.in_data;
                        sum <= sum + stream.in_data;
                    end
                    DATA_LO: begin
                        wr_en        <= 1'b1;
                        wr_data      <= {hi, stream.in_data};
                        words_loaded <= words_loaded + 1'b1;
                        sum          <= sum + stream.in_data;
                    end
                    default: ;
                endcase
            end
            if (next_state == LEN_L && state != LEN_L) begin
                cpu_hold     <= 1'b1;
                done         <= 1'b0;
                error        <= 1'b0;
                sum          <= '0;
                wr_addr      <= '0;
                words_loaded <= '0;
            end
            if (next_state == DONE && state != DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (next_state == ERR && state != ERR) begin
                error    <= 1'b1;
                cpu_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avr_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_avr_prog_loader
// Self-checking bench for avr_prog_loader: a table of frames with expected
// writes and final status, a scoreboard queue of expected memory writes, and
// hand-written sequences for full-depth load, mid-frame reset and (when
// LOADER_TIMEOUT_EN is defined) the inter-byte timeout.
// -----------------------------------------------------------------------------
module tb_avr_prog_loader;

    localparam int ADDR_W = 9;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    // Free-running clock; the design acts on the rising edge.
    always #5 CLK = ~CLK;

    avr_prog_loader_if bus();

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    avr_prog_loader #(
        .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'h55),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .stream(bus),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    // Bytes and words are right-aligned: byte k of n is bytes[8*(n-1-k) +: 8].
    typedef struct {
        bit           rst_first;
        int           n;
        logic [127:0] bytes;
        int           nw;
        logic [63:0]  words;
        logic         exp_done;
        logic         exp_error;
        logic         exp_hold;
        int           exp_wl;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   vec_count = 0;
    int   err_count = 0;

    // One comparison: counts it, and reports a mismatch on a single line.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_count++;
        if (act !== req) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin : monitor
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_wr_en", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("wr_addr", 32'(wr_addr), 32'(e.addr));
                check_output("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_output({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_output({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_output({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check_output({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic finish_frame();
        bus.in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        wr_t w;
        if (v.rst_first) do_reset();
        for (int j = 0; j < v.nw; j++) begin
            w.addr = ADDR_W'(j);
            w.data = v.words[16*(v.nw-1-j) +: 16];
            exp_q.push_back(w);
        end
        for (int k = 0; k < v.n; k++) begin
            send_byte(v.bytes[8*(v.n-1-k) +: 8]);
        end
        finish_frame();
    endtask

    task automatic check_status(input string tag, input vec_t v);
        check_output({tag, "_done"}, 32'(done), 32'(v.exp_done));
        check_output({tag, "_error"}, 32'(error), 32'(v.exp_error));
        check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(v.exp_hold));
        check_output({tag, "_words_loaded"}, 32'(words_loaded), 32'(v.exp_wl));
        check_output({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        wr_t        w;
        int         cycles;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Good two-word frame.
        vecs[0] = '{1'b1, 8, 128'h55020011223344_54, 2, 64'h1122_3344, 1'b1, 1'b0, 1'b0, 2};
        // Same frame with a bad checksum, restarted straight from DONE.
        vecs[1] = '{1'b0, 8, 128'h55020011223344_55, 2, 64'h1122_3344, 1'b0, 1'b1, 1'b1, 2};
        // Leading junk discarded, zero-length frame.
        vecs[2] = '{1'b1, 6, 128'h00AA55000000, 0, 64'h0, 1'b1, 1'b0, 1'b0, 0};
        // LEN = 0x0201 exceeds a 512-word memory.
        vecs[3] = '{1'b0, 3, 128'h550102, 0, 64'h0, 1'b0, 1'b1, 1'b1, 0};
        // SYNC_BYTE as data inside a frame, restarted from ERR.
        vecs[4] = '{1'b0, 10, 128'h55030055015502AABBEB, 3, 64'h5501_5502_AABB, 1'b1, 1'b0, 1'b0, 3};
        // Non-sync bytes ignored in DONE, then a one-word frame.
        vecs[5] = '{1'b0, 8, 128'h1234550100DEAD74, 1, 64'hDEAD, 1'b1, 1'b0, 1'b0, 1};

        // Reset state, then in_ready rises once RST drops.
        @(posedge CLK);
        #1;
        check_reset_state("reset");
        RST = 1'b0;
        #1;
        check_output("reset_in_ready_after", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
            check_status($sformatf("v%0d", i), vecs[i]);
        end

        // Full-depth load: 512 words, wr_addr wraps back to 0 afterwards.
        do_reset();
        s = 8'h02;
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h02);
        for (int i = 0; i < 512; i++) begin
            w.addr = ADDR_W'(i);
            w.data = 16'(i) ^ 16'hA500;
            exp_q.push_back(w);
            send_byte(w.data[15:8]);
            send_byte(w.data[7:0]);
            s = s + w.data[15:8] + w.data[7:0];
        end
        send_byte(8'(8'h00 - s));
        finish_frame();
        check_output("full_done", 32'(done), 32'd1);
        check_output("full_error", 32'(error), 32'd0);
        check_output("full_words_loaded", 32'(words_loaded), 32'd512);
        check_output("full_wr_addr_wrap", 32'(wr_addr), 32'd0);
        check_output("full_pending_writes", 32'(exp_q.size()), 32'd0);

        // Reset after the 3rd data byte of a 4-word frame; one word has been written.
        do_reset();
        w.addr = '0;
        w.data = 16'h0102;
        exp_q.push_back(w);
        send_byte(8'h55);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        bus.in_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_state("midrst");
        RST = 1'b0;
        #1;
        check_output("midrst_pending_writes", 32'(exp_q.size()), 32'd0);
        apply_stimulus(vecs[0]);
        check_status("midrst_reload", vecs[0]);

`ifdef LOADER_TIMEOUT_EN
        // Stall inside a frame: error after the timeout, no write strobe.
        do_reset();
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAB);
        bus.in_valid = 1'b0;
        cycles = 0;
        while (error !== 1'b1 && cycles < 80) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        check_output("timeout_error", 32'(error), 32'd1);
        check_output("timeout_window", 32'((cycles >= 50) && (cycles <= 52)), 32'd1);
        check_output("timeout_cpu_hold", 32'(cpu_hold), 32'd1);
        check_output("timeout_words_loaded", 32'(words_loaded), 32'd0);
`else
        cycles = 0;
`endif

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/avr_prog_loader.md
Name: avr_prog_loader

Overview:
- Upstream of the program memory: receives a framed byte stream (host/UART side) and writes 16-bit instruction words into the program memory write port.
- Holds the CPU and fetch stage in reset (cpu_hold) while a load is in progress; releases them after a load completes with a valid checksum.
- Single-clock, byte-level valid/ready input; one program word written per two accepted data bytes.

Parameters:
- ADDR_W, 9, program memory word-address width; memory depth = 2^ADDR_W words.
- SYNC_BYTE, 8'h55, frame start marker.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in CLK cycles; used only when LOADER_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer happens when in_valid && in_ready.
- wr_en  output  1  program memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  program memory word address.
- wr_data  output  16  word to write.
- cpu_hold  output  1  OR'd into the CPU/fetch RST by the top level.
- done  output  1  last load completed, checksum good.
- error  output  1  last load aborted or failed.
- words_loaded  output  ADDR_W+1  count of words written in the current/last frame.

Behaviour:
- Reset is CLK, RST synchronous, active-high. On reset:
  - state=IDLE, in_ready=0 during the reset cycle, then 1.
  - wr_en=0, wr_addr=0, wr_data=0, words_loaded=0.
  - cpu_hold=1, done=0, error=0.
- Frame format: SYNC_BYTE, LEN_L, LEN_H, then 2*LEN data bytes, then CSUM.
  - LEN is the 16-bit word count.
  - Within each word, the first byte goes to wr_data[15:8] and the second to wr_data[7:0]. This is the ROM image byte order; the program memory swaps bytes on read.
- Checksum: 8-bit running sum of LEN_L, LEN_H, all data bytes and CSUM, modulo 256. It must equal 8'h00.
- in_ready=1 in every state except during reset. No backpressure is otherwise generated.
- States (transitions happen only on an accepted byte unless noted):
  - IDLE: byte==SYNC_BYTE -> LEN_L. Any other byte is discarded. cpu_hold keeps its current value.
  - LEN_L: store the byte, add it to the sum -> LEN_H. On entering LEN_L, cpu_hold=1, done=0, error=0, sum=0, wr_addr=0, words_loaded=0.
  - LEN_H: form LEN.
    - LEN > 2^ADDR_W -> ERR.
    - LEN==0 -> CSUM.
    - Otherwise -> DATA_HI.
  - DATA_HI: latch the byte into the high half -> DATA_LO.
  - DATA_LO: the registered outputs in the next cycle are wr_en=1, wr_data={hi,byte}, wr_addr=current word index. words_loaded increments in that same cycle. If this was word LEN-1 -> CSUM, else -> DATA_HI.
  - CSUM: sum+byte==0 -> DONE, else -> ERR.
  - DONE: done=1, cpu_hold=0. A SYNC_BYTE restarts the load (-> LEN_L); other bytes are ignored.
  - ERR: error=1, cpu_hold stays 1. A SYNC_BYTE restarts (-> LEN_L); other bytes are ignored.
- Write latency: wr_en asserts exactly 1 cycle after the low byte is accepted. wr_addr holds its value for the wr_en cycle, then advances by 1. wr_addr wraps only on a full-depth load, which ends in CSUM.
- Inside a frame, SYNC_BYTE is ordinary data and does not resync.
- RST mid-frame aborts the load immediately and returns all outputs to their reset values. Words already written remain in memory.
- Back-to-back bytes (in_valid held high every cycle) must be sustained with no dropped bytes.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter counts cycles since the last accepted byte while in LEN_L, LEN_H, DATA_HI, DATA_LO or CSUM.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to ERR (error=1, cpu_hold=1).
  - The counter clears on every accepted byte and on entry to IDLE, DONE or ERR.
- Not defined: no counter exists, and a stalled frame waits indefinitely.

Test Plan:
- Reset then stream 55 02 00 11 22 33 44 54 -> two wr_en pulses: addr0=16'h1122, addr1=16'h3344. Then done=1, error=0, cpu_hold falls, words_loaded=2.
- Same frame with CSUM=55 -> both words written, error=1, done=0, cpu_hold stays 1.
- Stream 00 AA 55 00 00 00 -> leading bytes discarded, zero-length frame, no wr_en, done=1.
- LEN=0x0201 with ADDR_W=9 (55 01 02) -> ERR immediately, no wr_en.
- Assert RST after the 3rd data byte of a 4-word frame -> outputs return to reset values next cycle. A following valid frame then loads correctly from addr 0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 55 01 00 AB then stall -> error=1 after 50 cycles, no wr_en.
